// File: rtl/fifo_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_access_arbiter
//  Purpose  : Round-robin arbiter sharing one single-access FIFO between two
//             producers and one consumer, with a flush/drain sequence.
//             Optional FIFO_ARB_LEVEL_EN adds level_o and overflow_err_o.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_access_arbiter #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wr_req_i,
    input  logic [FIFO_WIDTH-1:0] wr_data0_i,
    input  logic [FIFO_WIDTH-1:0] wr_data1_i,
    output logic [1:0]            wr_gnt_o,
    input  logic                  rd_req_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [FIFO_WIDTH-1:0] rd_data_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    output logic [FIFO_WIDTH-1:0] data_in_o,
    input  logic [FIFO_WIDTH-1:0] data_out_i,
    input  logic                  full_i,
    input  logic                  empty_i
`ifdef FIFO_ARB_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
    output logic                  overflow_err_o
`endif
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [1:0]    PTR_WR0 = 2'd0;
    localparam logic [1:0]    PTR_WR1 = 2'd1;
    localparam logic [1:0]    PTR_RD  = 2'd2;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [1:0]              ptr_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic [1:0]              wr_gnt_q;
    logic                    rd_gnt_q;
    logic                    rd_valid_q;
    logic                    flush_done_q;
    logic                    write_en_q;
    logic                    read_en_q;
    logic [FIFO_WIDTH-1:0]   data_in_q;

    logic [2:0]              elig_w;
    logic                    win_valid_w;
    logic [1:0]              win_w;
    logic [2:0]              rot_sum_w;
    logic [1:0]              ptr_d;

    // Occupancy once the operation currently on the FIFO port has landed;
    // decisions use this so back-to-back grants never over/underflow.
    assign cnt_d = cnt_q + {{(CW-1){1'b0}}, write_en_q} - {{(CW-1){1'b0}}, read_en_q};

    assign elig_w[0] = wr_req_i[0] && !wr_gnt_q[0] && (cnt_d < C_DEPTH) && !full_i;
    assign elig_w[1] = wr_req_i[1] && !wr_gnt_q[1] && (cnt_d < C_DEPTH) && !full_i;
    assign elig_w[2] = rd_req_i    && !rd_gnt_q    && (cnt_d != '0)     && !empty_i;

    // Scan from the farthest slot back to ptr so the closest eligible one wins.
    always_comb begin
        win_valid_w = 1'b0;
        win_w       = ptr_q;
        rot_sum_w   = '0;
        for (int k = 2; k >= 0; k--) begin
            rot_sum_w = {1'b0, ptr_q} + 3'(k);
            if (rot_sum_w >= 3'd3) begin
                rot_sum_w = rot_sum_w - 3'd3;
            end
            if (elig_w[rot_sum_w[1:0]]) begin
                win_valid_w = 1'b1;
                win_w       = rot_sum_w[1:0];
            end
        end
    end

    assign ptr_d = (win_w == PTR_RD) ? PTR_WR0 : (win_w + 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ARB;
            ptr_q        <= PTR_WR0;
            cnt_q        <= '0;
            wr_gnt_q     <= 2'b00;
            rd_gnt_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            data_in_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            wr_gnt_q     <= 2'b00;
            rd_gnt_q     <= 1'b0;
            rd_valid_q   <= rd_gnt_q;
            flush_done_q <= 1'b0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            data_in_q    <= '0;
            case (state_q)
                ST_ARB: begin
                    if (flush_i) begin
                        state_q <= ST_FLUSH;
                    end else if (win_valid_w) begin
                        ptr_q <= ptr_d;
                        if (win_w == PTR_RD) begin
                            rd_gnt_q  <= 1'b1;
                            read_en_q <= 1'b1;
                        end else begin
                            wr_gnt_q[win_w[0]] <= 1'b1;
                            write_en_q         <= 1'b1;
                            data_in_q          <= (win_w == PTR_WR1) ? wr_data1_i : wr_data0_i;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_d != '0) begin
                        read_en_q <= 1'b1;
                    end else begin
                        state_q      <= ST_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_ARB;
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign wr_gnt_o     = wr_gnt_q;
    assign rd_gnt_o     = rd_gnt_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = data_out_i;
    assign flush_done_o = flush_done_q;
    assign write_en_o   = write_en_q;
    assign read_en_o    = read_en_q;
    assign data_in_o    = data_in_q;

`ifdef FIFO_ARB_LEVEL_EN
    logic overflow_err_q;

    // Sticky: any disagreement between our count and the FIFO's own flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err_q <= 1'b0;
        end else if (((cnt_q == C_DEPTH) ^ full_i) || ((cnt_q == '0) ^ empty_i)) begin
            overflow_err_q <= 1'b1;
        end
    end

    assign level_o        = cnt_q;
    assign overflow_err_o = overflow_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_arbiter.sv
`default_nettype none
// Testbench for fifo_access_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference.
module tb_fifo_access_arbiter;
    localparam int W = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   wr_req = 2'b00;
    logic [W-1:0] wr_data0 = '0;
    logic [W-1:0] wr_data1 = '0;
    logic [1:0]   wr_gnt;
    logic         rd_req = 1'b0;
    logic         rd_gnt, rd_valid;
    logic [W-1:0] rd_data;
    logic         flush = 1'b0;
    logic         flush_done, write_en, read_en;
    logic [W-1:0] data_in, data_out;
    logic         full, empty;
`ifdef FIFO_ARB_LEVEL_EN
    logic [$clog2(D+1)-1:0] level;
    logic                   overflow_err;
`endif

    always #5 clk = ~clk;

    fifo_access_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .wr_req_i(wr_req), .wr_data0_i(wr_data0), .wr_data1_i(wr_data1), .wr_gnt_o(wr_gnt),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .flush_i(flush), .flush_done_o(flush_done),
        .write_en_o(write_en), .read_en_o(read_en), .data_in_o(data_in),
        .data_out_i(data_out), .full_i(full), .empty_i(empty)
`ifdef FIFO_ARB_LEVEL_EN
        , .level_o(level), .overflow_err_o(overflow_err)
`endif
    );

    // Simple FIFO the arbiter sits in front of
    logic [W-1:0] mem [D];
    logic [3:0]   wp, rp;
    int           env_cnt;
    logic         force_full = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0; rp <= '0; env_cnt <= 0; data_out <= '0;
        end else begin
            if (write_en) begin mem[wp] <= data_in; wp <= wp + 4'd1; end
            if (read_en)  begin data_out <= mem[rp]; rp <= rp + 4'd1; end
            env_cnt <= env_cnt + int'(write_en) - int'(read_en);
        end
    end
    assign full  = (env_cnt >= D) || force_full;
    assign empty = (env_cnt <= 0);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_ptr, m_issued, m_state;   // state: 0 arbitrate, 1 drain, 2 done
    logic [1:0]   m_wg;
    logic         m_rg, m_we, m_re;
    logic [W-1:0] m_din, m_rdata;
    logic [W-1:0] m_q[$];
    logic [1:0]   e_wg;
    logic         e_rg, e_we, e_re, e_rv, e_fd;
    logic [W-1:0] e_din;

    task automatic model_reset();
        m_ptr = 0; m_issued = 0; m_state = 0;
        m_wg = 2'b00; m_rg = 1'b0; m_we = 1'b0; m_re = 1'b0;
        m_din = '0; m_rdata = '0;
        m_q.delete();
    endtask

    // Predicts outputs after the coming edge from the current inputs.
    task automatic model_edge();
        bit el[3];
        int win;
        e_wg = 2'b00; e_rg = 1'b0; e_we = 1'b0; e_re = 1'b0; e_fd = 1'b0; e_din = '0;
        e_rv = m_rg;
        if (m_we) m_q.push_back(m_din);
        if (m_re && m_q.size() > 0) m_rdata = m_q.pop_front();
        case (m_state)
            0: begin
                if (flush) begin
                    m_state = 1;
                end else begin
                    el[0] = wr_req[0] && !m_wg[0] && (m_issued < D) && !full;
                    el[1] = wr_req[1] && !m_wg[1] && (m_issued < D) && !full;
                    el[2] = rd_req && !m_rg && (m_issued > 0) && !empty;
                    win = -1;
                    for (int k = 0; k < 3; k++) begin
                        if (win < 0 && el[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
                    end
                    if (win == 2) begin
                        e_rg = 1'b1; e_re = 1'b1; m_issued--;
                    end else if (win >= 0) begin
                        e_wg[win] = 1'b1; e_we = 1'b1; m_issued++;
                        e_din = (win == 1) ? wr_data1 : wr_data0;
                    end
                    if (win >= 0) m_ptr = (win + 1) % 3;
                end
            end
            1: begin
                if (m_issued > 0) begin e_re = 1'b1; m_issued--; end
                else begin m_state = 2; e_fd = 1'b1; end
            end
            default: m_state = 0;
        endcase
        m_wg = e_wg; m_rg = e_rg; m_we = e_we; m_re = e_re; m_din = e_din;
    endtask

    task automatic step_and_check(input string tag);
        model_edge();
        @(posedge clk); #1;
        check({tag, ".ctrl"}, {57'd0, wr_gnt, rd_gnt, write_en, read_en, rd_valid, flush_done},
              {57'd0, e_wg, e_rg, e_we, e_re, e_rv, e_fd});
        check({tag, ".data_in"}, {32'd0, data_in}, {32'd0, e_din});
        if (e_rv) check({tag, ".rd_data"}, {32'd0, rd_data}, {32'd0, m_rdata});
        check({tag, ".we_re_excl"}, {63'd0, write_en & read_en}, 64'd0);
`ifdef FIFO_ARB_LEVEL_EN
        check({tag, ".level"}, 64'(level), 64'(m_q.size()));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {wr_gnt, rd_gnt, rd_valid, flush_done, write_en, read_en, data_in, rd_data}, 64'd0);
        check({tag, ".hi"}, {62'd0, data_in[W-1], rd_data[W-1]}, 64'd0);
    endtask

    task automatic do_reset();
        wr_req = 2'b00; rd_req = 1'b0; flush = 1'b0; force_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] wr;
        logic       rd;
        logic       fl;
        logic [6:0] exp;   // {wr_gnt[1:0], rd_gnt, write_en, read_en, rd_valid, flush_done}
    } vec_t;

    vec_t vt[16];
    int   gcnt, wait_n;
    bit   got;

    initial begin
        vt[0]  = '{2'b01, 1'b0, 1'b0, 7'b01_0_1_0_0_0};
        vt[1]  = '{2'b00, 1'b1, 1'b0, 7'b00_0_0_0_0_0};  // FIFO still reports empty
        vt[2]  = '{2'b00, 1'b1, 1'b0, 7'b00_1_0_1_0_0};
        vt[3]  = '{2'b10, 1'b1, 1'b0, 7'b10_0_1_0_1_0};
        vt[4]  = '{2'b11, 1'b1, 1'b0, 7'b01_0_1_0_0_0};
        vt[5]  = '{2'b11, 1'b1, 1'b0, 7'b10_0_1_0_0_0};
        vt[6]  = '{2'b11, 1'b1, 1'b0, 7'b00_1_0_1_0_0};
        vt[7]  = '{2'b11, 1'b1, 1'b0, 7'b01_0_1_0_1_0};
        vt[8]  = '{2'b00, 1'b0, 1'b1, 7'b00_0_0_0_0_0};
        vt[9]  = '{2'b11, 1'b1, 1'b0, 7'b00_0_0_1_0_0};
        vt[10] = '{2'b11, 1'b1, 1'b1, 7'b00_0_0_1_0_0};
        vt[11] = '{2'b11, 1'b1, 1'b0, 7'b00_0_0_1_0_0};
        vt[12] = '{2'b11, 1'b1, 1'b0, 7'b00_0_0_0_0_1};
        vt[13] = '{2'b11, 1'b1, 1'b0, 7'b00_0_0_0_0_0};
        vt[14] = '{2'b11, 1'b1, 1'b0, 7'b10_0_1_0_0_0};
        vt[15] = '{2'b11, 1'b1, 1'b0, 7'b01_0_1_0_0_0};

        #2 check_all_zero("reset_outputs");
        do_reset();
        check_all_zero("post_reset");

        // ---- directed vector table ----
        for (int i = 0; i < 16; i++) begin
            wr_req = vt[i].wr; rd_req = vt[i].rd; flush = vt[i].fl;
            wr_data0 = 32'h1000_0000 + i; wr_data1 = 32'h2000_0000 + i;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {57'd0, wr_gnt, rd_gnt, write_en, read_en, rd_valid, flush_done}, {57'd0, vt[i].exp});
        end

        // ---- fill to depth with wr0 held, then a read unblocks it ----
        do_reset();
        wr_req = 2'b01; gcnt = 0;
        for (int i = 0; i < 45; i++) begin
            wr_data0 = 32'hB000_0000 + i;
            @(posedge clk); #1;
            if (wr_gnt[0]) gcnt++;
        end
        check("fill_grant_count", 64'(gcnt), 64'(D));
        rd_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk); #1;
            if (rd_gnt) begin got = 1'b1; rd_req = 1'b0; end
        end
        check("full_rd_gnt", {63'd0, got}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk); #1;
            if (wr_gnt[0]) got = 1'b1;
        end
        check("full_wr0_regrant", {63'd0, got}, 64'd1);
        wr_req = 2'b00;

        // ---- read on empty FIFO blocked until a write lands ----
        do_reset();
        rd_req = 1'b1; gcnt = 0;
        repeat (5) begin @(posedge clk); #1; if (rd_gnt) gcnt++; end
        check("empty_no_rd_gnt", 64'(gcnt), 64'd0);
        wr_req = 2'b10; wr_data1 = 32'hA5A5_0001; got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk); #1;
            if (wr_gnt[1]) begin got = 1'b1; wr_req = 2'b00; end
        end
        check("wr1_gnt", {63'd0, got}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk); #1;
            if (rd_gnt) begin got = 1'b1; rd_req = 1'b0; end
        end
        check("rd_gnt_after_write", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        check("rd_valid", {63'd0, rd_valid}, 64'd1);
        check("rd_data", {32'd0, rd_data}, {32'd0, 32'hA5A5_0001});

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 500; i++) begin
            if (i < 250) begin
                wr_req = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
                rd_req = ($urandom_range(0, 3) == 0);
            end else begin
                wr_req = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                rd_req = ($urandom_range(0, 3) != 0);
            end
            flush    = ($urandom_range(0, 39) == 0);
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            step_and_check($sformatf("rnd%0d", i));
            if (i == 300) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async_reset");
                @(posedge clk); #1 rst = 1'b0;
                model_reset();
            end
        end
        wr_req = 2'b00; rd_req = 1'b0; flush = 1'b0;

`ifdef FIFO_ARB_LEVEL_EN
        // ---- level tracking and sticky flag disagreement ----
        do_reset();
        wr_req = 2'b01; gcnt = 0;
        for (int i = 0; i < 12 && gcnt < 3; i++) begin
            @(posedge clk); #1;
            if (wr_gnt[0]) gcnt++;
        end
        wr_req = 2'b00;
        repeat (2) @(posedge clk); #1;
        check("level3", 64'(level), 64'd3);
        check("ovf_clear", {63'd0, overflow_err}, 64'd0);
        force_full = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("ovf_set", {63'd0, overflow_err}, 64'd1);
        force_full = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("ovf_sticky", {63'd0, overflow_err}, 64'd1);
        do_reset();
        check("ovf_rst", {63'd0, overflow_err}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
